write_master: RTL and testbench

- AXI4 memory-mapped write master for the DMA datapath.
- On a start pulse it drains a first-word-fall-through (FWFT) FIFO and writes `i_total_len` bytes to memory starting at `i_dst_addr`, as one or more INCR bursts.
- Sits between the DMA read-side FIFO and the AXI interconnect. Pulses `o_write_done` once the last write response has been accepted.

---
 rtl/write_master_pkg.sv | 25 ++
 rtl/write_master_if.sv | 51 +++++
 rtl/write_master.sv | 205 ++++++++++++++++++++
 tb/tb_write_master.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_master_pkg.sv
// -----------------------------------------------------------------------------
// write_master_pkg
// Shared DMA definitions for the AXI4 write master:
//   - AXI encodings for the burst type, the beat size and the OKAY response
//   - the 4 KB page size that no AXI burst may cross
//   - the write-master FSM state enum
// -----------------------------------------------------------------------------
package write_master_pkg;

   localparam logic [1:0]  BURST_INCR  = 2'b01;
   localparam logic [2:0]  SIZE_4B     = 3'b010;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;

   // Page size in bytes. The width leaves room for the value 4096 itself.
   localparam logic [12:0] BOUNDARY_4K = 13'h1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_DONE
   } wm_state_t;

endpackage

// File: rtl/write_master_if.sv
// -----------------------------------------------------------------------------
// write_master_if
// AXI4 write-channel bundle (AW, W and B) between the DMA write master and the
// interconnect.
//   master modport : drives AW/W payload and valids plus bready; samples the
//                    readies, bresp and bvalid
//   slave  modport : the mirror image, used by memory models and interconnect
// Parameters: ADDR_WIDTH (address bits), DATA_WIDTH (data bits, strobes are
// DATA_WIDTH/8).
// -----------------------------------------------------------------------------
interface write_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;

   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/write_master.sv
// -----------------------------------------------------------------------------
// write_master
// AXI4 write master for the DMA datapath. A start pulse in IDLE drains an FWFT
// FIFO and writes i_total_len bytes to memory from i_dst_addr, as a sequence of
// INCR bursts with a single burst outstanding at a time. No burst crosses a
// 4 KB page. o_write_done pulses for one cycle after the last write response.
//
// Ports:
//   clk, reset_n   clock (rising edge) and asynchronous active-low reset
//   i_start        start pulse, only looked at in IDLE
//   i_dst_addr     destination byte address (word aligned)
//   i_total_len    transfer length in bytes
//   o_write_done   one-cycle completion pulse
//   i_fifo_empty   FIFO empty flag
//   o_fifo_rd_en   FIFO pop, one per W handshake
//   i_w_data       FIFO head word (first-word-fall-through)
//   m_axi          AXI4 AW/W/B channels (master side)
// -----------------------------------------------------------------------------
module write_master
   import write_master_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,   // only 32 is supported
   parameter int C_MAX_BURST_LEN    = 16    // 1..256
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          i_start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_dst_addr,
   input  logic [31:0]                   i_total_len,
   output logic                          o_write_done,
   input  logic                          i_fifo_empty,
   output logic                          o_fifo_rd_en,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] i_w_data,
   write_master_if.master                m_axi
);

   localparam int          STRB_W    = C_M_AXI_DATA_WIDTH / 8;
   localparam logic [30:0] MAX_BEATS = 31'(C_MAX_BURST_LEN);

   // Beats for the next burst: limited by what is left, by the burst cap and
   // by the words remaining before the next 4 KB page.
   function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                              input logic [30:0] rem);
      logic [12:0] room_bytes;
      logic [30:0] room_beats;
      logic [30:0] n;
      room_bytes = BOUNDARY_4K - {1'b0, page_off};
      room_beats = 31'(room_bytes >> 2);
      n = rem;
      if (n > MAX_BEATS) begin
         n = MAX_BEATS;
      end
      if (n > room_beats) begin
         n = room_beats;
      end
      return 9'(n);
   endfunction

   wm_state_t                   state_reg;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr_reg;      // start address of current burst
   logic [30:0]                 rem_reg;       // beats still to write, incl. current burst
   logic [8:0]                  beats_reg;     // beats in current burst
   logic [7:0]                  awlen_reg;
   logic [7:0]                  beat_cnt_reg;  // beat index within current burst
   logic [1:0]                  tail_reg;      // valid bytes in the final word, 0 = all four
   logic                        awvalid_reg;
   logic                        bready_reg;
   logic                        done_reg;

   // Values loaded on start
   logic [30:0] start_rem;
   logic [8:0]  start_beats;
   // Values after the current burst's response
   logic [C_M_AXI_ADDR_WIDTH-1:0] next_addr;
   logic [30:0] next_rem;
   logic [8:0]  next_beats;

   logic              in_w;
   logic              w_valid;
   logic              w_hs;
   logic              last_beat;
   logic              final_beat;
   logic [STRB_W-1:0] tail_mask;
   logic              unused_bresp_okay;

   assign start_rem   = {1'b0, i_total_len[31:2]} + {30'd0, |i_total_len[1:0]};
   assign start_beats = burst_beats(i_dst_addr[11:0], start_rem);

   assign next_addr   = addr_reg + {{(C_M_AXI_ADDR_WIDTH-11){1'b0}}, beats_reg, 2'b00};
   assign next_rem    = rem_reg - {22'd0, beats_reg};
   assign next_beats  = burst_beats(next_addr[11:0], next_rem);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         addr_reg     <= '0;
         rem_reg      <= '0;
         beats_reg    <= '0;
         awlen_reg    <= '0;
         beat_cnt_reg <= '0;
         tail_reg     <= '0;
         awvalid_reg  <= 1'b0;
         bready_reg   <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (i_start) begin
                  addr_reg     <= i_dst_addr;
                  rem_reg      <= start_rem;
                  beats_reg    <= start_beats;
                  tail_reg     <= i_total_len[1:0];
                  beat_cnt_reg <= '0;
                  if (start_rem == '0) begin
                     // Zero-length request: complete without touching the bus
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end else begin
                     awlen_reg   <= 8'(start_beats - 9'd1);
                     awvalid_reg <= 1'b1;
                     state_reg   <= ST_AW;
                  end
               end
            end

            ST_AW: begin
               if (awvalid_reg && m_axi.awready) begin
                  awvalid_reg <= 1'b0;
                  state_reg   <= ST_W;
               end
            end

            ST_W: begin
               if (w_hs) begin
                  if (last_beat) begin
                     beat_cnt_reg <= '0;
                     bready_reg   <= 1'b1;
                     state_reg    <= ST_B;
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 8'd1;
                  end
               end
            end

            ST_B: begin
               // The response code is deliberately ignored.
               if (bready_reg && m_axi.bvalid) begin
                  bready_reg <= 1'b0;
                  addr_reg   <= next_addr;
                  rem_reg    <= next_rem;
                  beats_reg  <= next_beats;
                  if (next_rem != '0) begin
                     awlen_reg   <= 8'(next_beats - 9'd1);
                     awvalid_reg <= 1'b1;
                     state_reg   <= ST_AW;
                  end else begin
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               done_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // W channel follows the FIFO head directly; wvalid depends on the FIFO flag
   // and registered state only, never on wready.
   assign in_w       = (state_reg == ST_W);
   assign w_valid    = in_w && !i_fifo_empty;
   assign w_hs       = w_valid && m_axi.wready;
   assign last_beat  = (beat_cnt_reg == awlen_reg);
   // Last beat of the last burst: the remaining count still includes this burst.
   assign final_beat = last_beat && (rem_reg == {22'd0, beats_reg});
   assign tail_mask  = (STRB_W'(1) << tail_reg) - STRB_W'(1);

   assign m_axi.awaddr  = addr_reg;
   assign m_axi.awlen   = awlen_reg;
   assign m_axi.awsize  = SIZE_4B;
   assign m_axi.awburst = BURST_INCR;
   assign m_axi.awvalid = awvalid_reg;

   assign m_axi.wvalid  = w_valid;
   assign m_axi.wdata   = in_w ? i_w_data : '0;
   assign m_axi.wlast   = in_w && last_beat;
   assign m_axi.wstrb   = !in_w                          ? '0        :
                          (final_beat && tail_reg != '0) ? tail_mask : '1;

   assign m_axi.bready  = bready_reg;

   assign o_fifo_rd_en  = w_hs;
   assign o_write_done  = done_reg;

   assign unused_bresp_okay = (m_axi.bresp == RESP_OKAY);

endmodule

// File: tb/tb_write_master.sv
// -----------------------------------------------------------------------------
// tb_write_master
// Self-checking bench for write_master. A randomising AXI slave and FIFO model
// drive the DUT; a reference model derives the expected bursts, beats and
// strobes from the address/length rules and a scoreboard compares them.
// -----------------------------------------------------------------------------
module tb_write_master;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } aw_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_t;

   logic        clk;
   logic        reset_n;
   logic        i_start;
   logic [31:0] i_dst_addr;
   logic [31:0] i_total_len;
   logic        o_write_done;
   logic        i_fifo_empty;
   logic        o_fifo_rd_en;
   logic [31:0] i_w_data;

   write_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

   write_master #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .C_MAX_BURST_LEN    (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_start      (i_start),
      .i_dst_addr   (i_dst_addr),
      .i_total_len  (i_total_len),
      .o_write_done (o_write_done),
      .i_fifo_empty (i_fifo_empty),
      .o_fifo_rd_en (o_fifo_rd_en),
      .i_w_data     (i_w_data),
      .m_axi        (m_axi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   aw_t exp_aw[$];
   w_t  exp_w[$];

   int unsigned fifo_word  = 32'hA000_0000;  // FIFO head value
   int unsigned model_word = 32'hA000_0000;  // next word the model expects
   bit          pop_pending = 0;
   int          hold_empty  = 0;
   int          b_owed      = 0;
   int          b_delay     = 0;
   int          aw_credit   = 0;
   int          done_cnt    = 0;
   int          pop_cnt     = 0;
   int          w_seen      = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: expected bursts and beats from address/length rules.
   task automatic model_xfer(input logic [31:0] addr, input logic [31:0] len);
      longint      rem;
      longint      b;
      longint      room;
      logic [31:0] a;
      int          tail;
      w_t          w;
      aw_t         aw;
      rem  = (longint'(len) + 3) / 4;
      a    = addr;
      tail = int'(len % 4);
      while (rem > 0) begin
         room = (4096 - longint'(a % 4096)) / 4;
         b = rem;
         if (b > 16)   b = 16;
         if (b > room) b = room;
         aw.addr = a;
         aw.len  = 8'(b - 1);
         exp_aw.push_back(aw);
         for (longint i = 0; i < b; i++) begin
            w.data = model_word;
            w.last = (i == b - 1);
            if (rem == b && i == b - 1 && tail != 0)
               w.strb = 4'((1 << tail) - 1);
            else
               w.strb = 4'hF;
            exp_w.push_back(w);
            model_word++;
         end
         rem = rem - b;
         a   = a + 32'(4 * b);
      end
   endtask

   // Slave and FIFO driver: updates shortly after each rising edge.
   initial begin
      m_axi.awready = 0;
      m_axi.wready  = 0;
      m_axi.bvalid  = 0;
      m_axi.bresp   = 0;
      i_fifo_empty  = 1;
      i_w_data      = fifo_word;
      forever begin
         @(posedge clk);
         #1;
         if (pop_pending) fifo_word++;
         pop_pending = 0;
         if (!reset_n) begin
            m_axi.awready = 0;
            m_axi.wready  = 0;
            m_axi.bvalid  = 0;
            b_delay       = 0;
         end else begin
            m_axi.awready = ($urandom_range(0, 1) == 0);
            m_axi.wready  = ($urandom_range(0, 3) != 0);
            if (m_axi.bvalid && !m_axi.bready) m_axi.bvalid = 0;
            if (!m_axi.bvalid && b_owed > 0) begin
               if (b_delay == 0) begin
                  m_axi.bvalid = 1;
                  m_axi.bresp  = 2'($urandom_range(0, 3));
                  b_delay      = $urandom_range(0, 3);
               end else begin
                  b_delay--;
               end
            end
         end
         if (hold_empty > 0) begin
            i_fifo_empty = 1;
            hold_empty--;
         end else begin
            i_fifo_empty = ($urandom_range(0, 4) == 0);
         end
         i_w_data = fifo_word;
      end
   end

   // Monitor / scoreboard: samples on the falling edge.
   initial begin
      aw_t ea;
      w_t  ew;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (m_axi.awvalid && m_axi.awready) begin
               chk("aw_one_outstanding", (aw_credit == 0 && b_owed == 0), 1);
               chk("aw_expected", (exp_aw.size() != 0), 1);
               if (exp_aw.size() != 0) begin
                  ea = exp_aw.pop_front();
                  chk("awaddr", m_axi.awaddr, ea.addr);
                  chk("awlen", m_axi.awlen, ea.len);
               end
               chk("awsize", m_axi.awsize, 3'b010);
               chk("awburst", m_axi.awburst, 2'b01);
               aw_credit = int'(m_axi.awlen) + 1;
            end
            if (m_axi.wvalid && m_axi.wready) begin
               chk("w_after_aw", (aw_credit > 0), 1);
               if (aw_credit > 0) aw_credit--;
               chk("rd_en_on_w", o_fifo_rd_en, 1);
               chk("w_expected", (exp_w.size() != 0), 1);
               if (exp_w.size() != 0) begin
                  ew = exp_w.pop_front();
                  chk("wdata", m_axi.wdata, ew.data);
                  chk("wstrb", m_axi.wstrb, ew.strb);
                  chk("wlast", m_axi.wlast, ew.last);
               end
               w_seen++;
               if (m_axi.wlast) b_owed++;
            end
            if (i_fifo_empty) begin
               chk("wvalid_when_empty", m_axi.wvalid, 0);
               chk("rd_en_when_empty", o_fifo_rd_en, 0);
            end
            if (m_axi.bvalid && m_axi.bready && b_owed > 0) b_owed--;
            if (o_write_done) done_cnt++;
         end
         if (o_fifo_rd_en) pop_cnt++;
         pop_pending = o_fifo_rd_en;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_awvalid"}, m_axi.awvalid, 0);
      chk({tag, "_awaddr"},  m_axi.awaddr, 0);
      chk({tag, "_awlen"},   m_axi.awlen, 0);
      chk({tag, "_awsize"},  m_axi.awsize, 3'b010);
      chk({tag, "_awburst"}, m_axi.awburst, 2'b01);
      chk({tag, "_wvalid"},  m_axi.wvalid, 0);
      chk({tag, "_wdata"},   m_axi.wdata, 0);
      chk({tag, "_wstrb"},   m_axi.wstrb, 0);
      chk({tag, "_wlast"},   m_axi.wlast, 0);
      chk({tag, "_bready"},  m_axi.bready, 0);
      chk({tag, "_done"},    o_write_done, 0);
      chk({tag, "_rd_en"},   o_fifo_rd_en, 0);
   endtask

   task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len,
                           input int gap_after, input bit poke_start);
      int  d0, p0, w0, cyc, n_beats;
      bit  gap_done;
      model_xfer(addr, len);
      n_beats  = int'((longint'(len) + 3) / 4);
      d0       = done_cnt;
      p0       = pop_cnt;
      w0       = w_seen;
      gap_done = 0;
      @(posedge clk); #1;
      i_dst_addr  = addr;
      i_total_len = len;
      i_start     = 1;
      @(posedge clk); #1;
      i_start     = 0;
      i_dst_addr  = $urandom;
      i_total_len = $urandom;
      cyc = 0;
      while (done_cnt == d0 && cyc < 3000) begin
         if (gap_after > 0 && !gap_done && (w_seen - w0) == gap_after) begin
            hold_empty = 5;
            gap_done   = 1;
         end
         if (poke_start && cyc == 10) begin
            i_start     = 1;
            i_dst_addr  = 32'h0000_7000;
            i_total_len = 40;
         end else begin
            i_start = 0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      i_start = 0;
      chk("done_pulse", done_cnt - d0, 1);
      if (len == 0) chk("len0_latency", (cyc <= 2), 1);
      chk("aw_all_issued", exp_aw.size(), 0);
      chk("w_all_issued", exp_w.size(), 0);
      chk("pop_count", pop_cnt - p0, n_beats);
      repeat (3) @(posedge clk);
      #1;
      chk("single_done", done_cnt - d0, 1);
      $display("xfer addr=0x%08h len=%0d beats=%0d cycles=%0d", addr, len, n_beats, cyc);
   endtask

   task automatic reset_mid_w();
      int d0, w0, cyc;
      model_xfer(32'h0000_5000, 64);
      d0 = done_cnt;
      w0 = w_seen;
      @(posedge clk); #1;
      i_dst_addr  = 32'h0000_5000;
      i_total_len = 64;
      i_start     = 1;
      @(posedge clk); #1;
      i_start = 0;
      cyc = 0;
      while ((w_seen - w0) < 2 && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("reset_reached_w", ((w_seen - w0) >= 2), 1);
      reset_n = 0;
      #2;
      check_reset_outputs("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1;
      exp_aw.delete();
      exp_w.delete();
      aw_credit = 0;
      b_owed    = 0;
      repeat (5) @(posedge clk);
      #1;
      model_word = fifo_word;
      chk("rst_no_done", done_cnt - d0, 0);
      chk("rst_idle_awvalid", m_axi.awvalid, 0);
      $display("reset mid-W after %0d beats", w_seen - w0);
   endtask

   initial begin
      logic [31:0] ra, rl;
      reset_n     = 0;
      i_start     = 0;
      i_dst_addr  = 0;
      i_total_len = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1;
      repeat (2) @(posedge clk);

      run_xfer(32'h8000_0000, 16, 0, 0);
      run_xfer(32'h8000_0100, 32, 0, 0);
      run_xfer(32'h0000_0000, 80, 0, 0);
      run_xfer(32'h0000_0FF0, 32, 0, 0);
      run_xfer(32'h0000_2000, 64, 3, 0);
      run_xfer(32'h0000_3000, 0,  0, 0);
      run_xfer(32'h0000_3000, 6,  0, 0);
      run_xfer(32'h0000_4000, 48, 0, 1);
      reset_mid_w();
      run_xfer(32'h0000_6000, 20, 0, 0);

      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0)
            ra = ($urandom & 32'hFFFF_F000) | 32'(4096 - 4 * $urandom_range(1, 24));
         else
            ra = $urandom & 32'hFFFF_FFFC;
         rl = $urandom_range(0, 160);
         run_xfer(ra, rl, (i % 4 == 1) ? 2 : 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
